// File: rtl/risc_pkg.sv
// Shared decode constants and scoreboard entry type for the pipelined RISC core.
package risc_pkg;

  localparam logic [5:0] OP_NOP    = 6'h00;
  localparam logic [5:0] OP_LOAD   = 6'h23;
  localparam logic [5:0] OP_STORE  = 6'h2B;
  localparam logic [5:0] OP_BRANCH = 6'h04;

  localparam int OPC_LSB = 26;
  localparam int OPC_W   = 6;
  localparam int RD_LSB  = 21;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 11;
  localparam int RD_W    = 5;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            is_load;
  } sb_entry_t;

  function automatic logic op_writes_rd(input logic [OPC_W-1:0] op);
    return !(op inside {OP_NOP, OP_STORE, OP_BRANCH});
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Decode-side bus of the hazard/forwarding unit.
// HAZARD_STATS_EN adds the stall/forward statistics counters.
interface hazard_fwd_unit_if #(
  parameter int IW    = 32,
  parameter int SELW  = 4,
  parameter int DEPTH = 3
);
  logic             id_valid;
  logic [IW-1:0]    id_inst;
  logic             flush;
  logic             stall;
  logic [SELW-1:0]  fwd_sel_a;
  logic [SELW-1:0]  fwd_sel_b;
  logic [DEPTH-1:0] slot_valid;
`ifdef HAZARD_STATS_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      fwd_cnt;
`endif

  modport master (
    output id_valid, id_inst, flush,
`ifdef HAZARD_STATS_EN
    input  stall_cnt, fwd_cnt,
`endif
    input  stall, fwd_sel_a, fwd_sel_b, slot_valid
  );

  modport slave (
    input  id_valid, id_inst, flush,
`ifdef HAZARD_STATS_EN
    output stall_cnt, fwd_cnt,
`endif
    output stall, fwd_sel_a, fwd_sel_b, slot_valid
  );
endinterface

// File: rtl/fwd_match.sv
// Priority search of the scoreboard for one source register; youngest producer wins.
module fwd_match
  import risc_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int RFW   = 5,
  parameter int SELW  = 4
) (
  input  sb_entry_t [DEPTH-1:0] slots,
  input  logic [RFW-1:0]        rs,
  output logic [SELW-1:0]       sel,
  output logic                  is_load_hit
);

  // Scan oldest to youngest so the lowest matching slot overwrites the rest.
  always_comb begin
    sel         = '0;
    is_load_hit = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slots[k].valid && (slots[k].rd[RFW-1:0] == rs) && (rs != '0)) begin
        sel         = SELW'(k + 1);
        is_load_hit = slots[k].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use hazard detection and operand forwarding between decode and ID_EXE.
// HAZARD_STATS_EN adds saturating stall_cnt / fwd_cnt outputs.
module hazard_fwd_unit
  import risc_pkg::*;
#(
  parameter int RFW        = 5,
  parameter int IW         = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  parameter int SELW       = 4
) (
  input logic               clk,
  input logic               reset,
  hazard_fwd_unit_if.slave  bus
);

  sb_entry_t [DEPTH-1:0] sb;
  sb_entry_t             entry;

  logic [OPC_W-1:0] opcode;
  logic [RFW-1:0]   rd_f;
  logic [RFW-1:0]   rs1_f;
  logic [RFW-1:0]   rs2_f;
  logic [SELW-1:0]  sel_a;
  logic [SELW-1:0]  sel_b;
  logic             load_a;
  logic             load_b;
  logic             haz_a;
  logic             haz_b;
  logic             stall;
  logic             unused_bits;

  assign opcode      = bus.id_inst[OPC_LSB +: OPC_W];
  assign rd_f        = bus.id_inst[RD_LSB +: RFW];
  assign rs1_f       = bus.id_inst[RS1_LSB +: RFW];
  assign rs2_f       = bus.id_inst[RS2_LSB +: RFW];
  assign unused_bits = ^bus.id_inst[RS2_LSB-1:0];

  fwd_match #(.DEPTH(DEPTH), .RFW(RFW), .SELW(SELW)) u_match_a (
    .slots       (sb),
    .rs          (rs1_f),
    .sel         (sel_a),
    .is_load_hit (load_a)
  );

  fwd_match #(.DEPTH(DEPTH), .RFW(RFW), .SELW(SELW)) u_match_b (
    .slots       (sb),
    .rs          (rs2_f),
    .sel         (sel_b),
    .is_load_hit (load_b)
  );

  // A load hit only stalls while it sits in a slot younger than LOAD_READY.
  assign haz_a = load_a && (sel_a <= SELW'(LOAD_READY));
  assign haz_b = load_b && (sel_b <= SELW'(LOAD_READY));
  assign stall = bus.id_valid && !bus.flush && (haz_a || haz_b);

  assign bus.stall     = stall;
  assign bus.fwd_sel_a = sel_a;
  assign bus.fwd_sel_b = sel_b;

  always_comb begin
    entry         = '0;
    entry.valid   = bus.id_valid && !stall && !bus.flush &&
                    op_writes_rd(opcode) && (rd_f != '0);
    entry.rd      = RD_W'(rd_f);
    entry.is_load = (opcode == OP_LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb <= '0;
    end else begin
      sb[DEPTH-1:1] <= sb[DEPTH-2:0];
      sb[0]         <= entry;
    end
  end

  always_comb begin
    bus.slot_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.slot_valid[k] = sb[k].valid;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
  logic        fwd_used;

  assign fwd_used = bus.id_valid && !stall && ((sel_a != '0) || (sel_b != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (fwd_used && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt;
  assign bus.fwd_cnt   = fwd_cnt;
`endif

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised hazard-detection and operand-forwarding unit for the pipelined RISC core; successor to the fixed two-source forwarding built into the register file.
Tracks destination registers of up to DEPTH in-flight instructions past decode in a shift-register scoreboard.
Produces per-operand forward selects, load-use stall and flush-driven bubble insertion.
Sits between the IF_ID register / decode and the ID_EXE register; its selects steer the operand muxes feeding ID_EXE.

Parameters:
RFW, 5, register index width (2^RFW architectural registers; register 0 reads as zero)
IW, 32, instruction width
DEPTH, 3, tracked stages after decode (slot 0 = EXE, slot 1 = MEM, slot DEPTH-1 = WB); legal range 2..8
LOAD_READY, 1, first slot index at which load data is forwardable; must be < DEPTH
SELW, 4, forward-select width; must be >= clog2(DEPTH+1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears scoreboard
id_valid  in  1  IF_ID holds a real instruction
id_inst  in  IW  instruction in decode
flush  in  1  squash decode instruction (taken branch)
stall  out  1  hold PC and IF_ID, insert bubble into ID_EXE
fwd_sel_a  out  SELW  source for rs1: 0 = register file, k+1 = slot k result
fwd_sel_b  out  SELW  source for rs2, same encoding
slot_valid  out  DEPTH  per-slot occupancy (debug/verification)

Behaviour:
- Field decode: opcode = id_inst[31:26], rd = [25:21], rs1 = [20:16], rs2 = [15:11].
- Writes-rd rule: opcode not in {OP_NOP, OP_STORE, OP_BRANCH} and rd != 0.
- Scoreboard: per slot {valid, rd, is_load}, all registers. Reset clears every valid bit asynchronously; stall = 0 and selects = 0 follow immediately.
- Issue, each rising edge:
  - Slots shift: slot k+1 <= slot k; slot DEPTH-1 is discarded.
  - Slot 0 <= decode entry when id_valid && !stall && !flush && writes-rd; otherwise slot 0 <= bubble (valid = 0).
- Forward search for each source rs:
  - Pick the smallest k with slot[k].valid && slot[k].rd == rs && rs != 0.
  - sel = k+1 on a match; 0 if no match. The youngest producer wins.
- Load-use hazard: the matched slot has is_load and k < LOAD_READY.
- stall = id_valid && !flush && (hazard on rs1 || hazard on rs2). Both stall and the selects are combinational from id_inst and scoreboard state: zero-cycle latency.
- While stall is high, the decode instruction is held. The bubble advances the load until k >= LOAD_READY, then stall drops and sel = k+1. With LOAD_READY = 1, a load-use stall lasts exactly one cycle.
- Flush and hazard in the same cycle: flush wins. stall = 0, bubble inserted, no decode entry captured.
- Selects are don't-care-free: they are driven even when id_valid = 0 (computed from fields) and are ignored downstream.
- Reset mid-stall: scoreboard empties, stall deasserts in the same cycle.

Optional Feature:
HAZARD_STATS_EN
- Defined: adds outputs stall_cnt[31:0] and fwd_cnt[31:0].
  - stall_cnt increments once per cycle with stall = 1.
  - fwd_cnt increments once per cycle in which either select is nonzero while id_valid && !stall.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package risc_pkg holds:
  - opcode constants OP_NOP = 6'h00, OP_LOAD = 6'h23, OP_STORE = 6'h2B, OP_BRANCH = 6'h04
  - field-position constants
  - the scoreboard-entry typedef {valid, rd, is_load}
- One sub-module, fwd_match: a combinational priority search over DEPTH slots for one source register, returning {sel, is_load_hit}. It is instantiated twice (rs1, rs2).

Test Plan:
1. Reset, then issue ADD r3 (rd = 3); next cycle decode uses rs1 = 3 -> fwd_sel_a = 1, stall = 0; the cycle after -> fwd_sel_a = 2.
2. LOAD r5 issued, next decode rs2 = 5 -> stall = 1 for exactly one cycle; then fwd_sel_b = 2, stall = 0; slot_valid shows the bubble at slot 0.
3. ADD r4 then SUB r4 back-to-back, decode reads r4 -> fwd_sel_a = 1 (youngest producer), never 2.
4. Decode writes/reads r0 (rd = 0, rs1 = 0) -> no scoreboard entry, fwd_sel_a = 0, no stall.
5. Load-use hazard coincident with flush = 1 -> stall = 0, slot 0 bubble next cycle; reset asserted during a stall -> stall = 0 and slot_valid = 0 immediately.
6. DEPTH = 5, LOAD_READY = 2 -> load-use stall lasts two cycles, then sel = 3; an entry leaves after 5 shifts, after which sel = 0.
